// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid side and the decode-facing output.
// Signal suffixes are from the fetch unit's point of view (master).
interface ifu_fetch_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req_o;
  logic [XLEN-1:0]        imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic                   imem_err_i;

  logic                   if_valid_o;
  logic                   if_ready_i;
  logic [XLEN-1:0]        if_pc_o;
  logic [INSTR_WIDTH-1:0] if_instr_o;
  logic                   if_fault_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    output if_valid_o, if_pc_o, if_instr_o, if_fault_o,
    input  if_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    input  if_valid_o, if_pc_o, if_instr_o, if_fault_o,
    output if_ready_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, one-entry output register.
// Optional fetch-fault reporting (misaligned redirect, imem_err_i) is enabled by IFU_FAULT_CHECK_EN.
module ifu_fetch #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int unsigned     INSTR_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  ifu_fetch_if.master     bus
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        req_pc_q, req_pc_d;
  logic [XLEN-1:0]        out_pc_q, out_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic                   drop_q, drop_d;
  logic                   rsp_err;

`ifdef IFU_FAULT_CHECK_EN
  assign rsp_err = bus.imem_err_i;
`else
  logic unused_err;
  assign unused_err = bus.imem_err_i;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_pc_d = out_pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    drop_d   = drop_q;

    unique case (state_q)
      S_REQ: begin
        if (bus.imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_pc_d = req_pc_q;
            instr_d  = bus.imem_rdata_i;
            fault_d  = rsp_err;
            valid_d  = 1'b1;
            state_d  = S_FULL;
          end
        end
      end
      S_FULL: begin
        // drop can only be set here after a fault redirect killed an in-flight fetch;
        // its stale response is swallowed here or, after the handshake, back in WAIT.
        if (bus.imem_rvalid_i) drop_d = 1'b0;
        if (valid_q && bus.if_ready_i) begin
          valid_d = 1'b0;
          state_d = drop_d ? S_WAIT : S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (bus.imem_gnt_i) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = drop_d ? S_WAIT : S_REQ;
      endcase
`ifdef IFU_FAULT_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        out_pc_d = redirect_pc_i;
        instr_d  = NOP;
        fault_d  = 1'b1;
        valid_d  = 1'b1;
        pc_d     = redirect_pc_i + XLEN'(4);
        state_d  = S_FULL;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_pc_q <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_pc_q <= out_pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.imem_req_o  = (state_q == S_REQ) && !rst;
  assign bus.imem_addr_o = pc_q;
  assign bus.if_valid_o  = valid_q;
  assign bus.if_pc_o     = out_pc_q;
  assign bus.if_instr_o  = instr_q;
`ifdef IFU_FAULT_CHECK_EN
  assign bus.if_fault_o  = fault_q;
`else
  assign bus.if_fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed literal checks plus randomized traffic against a
// transaction-level model (next PC, in-flight fetch live/killed, held output slot).
module tb_ifu_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [63:0] rpc;

  int n_checks = 0;
  int n_pass   = 0;

  ifu_fetch_if #(.XLEN(64), .INSTR_WIDTH(32)) bus ();

  ifu_fetch #(.XLEN(64), .RESET_PC(RESET_PC), .INSTR_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Model: m_pend 0 = nothing in flight, 1 = live fetch of m_ppc, 2 = killed fetch.
  logic [63:0] m_pc, m_ppc, m_opc;
  logic [31:0] m_oin;
  logic        m_v, m_of;
  int          m_pend;

  task automatic model_reset();
    m_pc = RESET_PC; m_ppc = '0; m_opc = '0; m_oin = NOP;
    m_v = 1'b0; m_of = 1'b0; m_pend = 0;
  endtask

  task automatic model_step();
    bit req_e, acc;
    req_e = !m_v && (m_pend == 0);
    acc   = m_v && bus.if_ready_i;
    if (m_pend != 0 && bus.imem_rvalid_i) begin
      if (m_pend == 1) begin
        m_v = 1'b1; m_opc = m_ppc; m_oin = bus.imem_rdata_i;
`ifdef IFU_FAULT_CHECK_EN
        m_of = bus.imem_err_i;
`else
        m_of = 1'b0;
`endif
      end
      m_pend = 0;
    end
    if (acc) m_v = 1'b0;
    if (req_e && bus.imem_gnt_i) begin
      m_pend = 1; m_ppc = m_pc; m_pc = m_pc + 64'd4;
    end
    if (redir) begin
      m_pc = rpc; m_v = 1'b0;
      if (m_pend == 1) m_pend = 2;
`ifdef IFU_FAULT_CHECK_EN
      if (rpc[1:0] != 2'b00) begin
        m_v = 1'b1; m_opc = rpc; m_oin = NOP; m_of = 1'b1; m_pc = rpc + 64'd4;
      end
`endif
    end
  endtask

  // Single compare process: model advances on each edge, outputs checked 1 time unit later.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      bit req_e;
      model_step();
      #1;
      req_e = !m_v && (m_pend == 0);
      chk("m_req", 64'(bus.imem_req_o), 64'(req_e));
      if (req_e) chk("m_addr", bus.imem_addr_o, m_pc);
      chk("m_valid", 64'(bus.if_valid_o), 64'(m_v));
      if (m_v) begin
        chk("m_pc", bus.if_pc_o, m_opc);
        chk("m_instr", 64'(bus.if_instr_o), 64'(m_oin));
        chk("m_fault", 64'(bus.if_fault_o), 64'(m_of));
      end
    end
  end

  task automatic clr_in();
    redir = 1'b0; rpc = '0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.imem_err_i = 1'b0; bus.if_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    bit          busy, g, rv, r;
    int          lat;
    rst = 1'b1;
    clr_in();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.if_valid_o), 64'd0);
    chk("rst_pc", bus.if_pc_o, 64'd0);
    chk("rst_instr", 64'(bus.if_instr_o), 64'(NOP));
    chk("rst_fault", 64'(bus.if_fault_o), 64'd0);

    // First fetch
    rst = 1'b0; bus.imem_gnt_i = 1'b1; #1;
    chk("first_req", 64'(bus.imem_req_o), 64'd1);
    chk("first_addr", bus.imem_addr_o, 64'h8000_0000);
    @(negedge clk);
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0010_0093;
    chk("wait_req", 64'(bus.imem_req_o), 64'd0);
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    chk("first_valid", 64'(bus.if_valid_o), 64'd1);
    chk("first_pc", bus.if_pc_o, 64'h8000_0000);
    chk("first_instr", 64'(bus.if_instr_o), 64'h0010_0093);
    chk("next_pc", bus.imem_addr_o, 64'h8000_0004);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.if_valid_o), 64'd1);
      chk("bp_instr", 64'(bus.if_instr_o), 64'h0010_0093);
      chk("bp_pc", bus.if_pc_o, 64'h8000_0000);
      chk("bp_req", 64'(bus.imem_req_o), 64'd0);
    end
    bus.if_ready_i = 1'b1;
    @(negedge clk);
    bus.if_ready_i = 1'b0;
    chk("acc_valid", 64'(bus.if_valid_o), 64'd0);
    chk("acc_req", 64'(bus.imem_req_o), 64'd1);
    chk("acc_addr", bus.imem_addr_o, 64'h8000_0004);

    // Redirect in WAIT drops the response
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0; redir = 1'b1; rpc = 64'h8000_0100;
    @(negedge clk);
    redir = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    chk("wr_valid", 64'(bus.if_valid_o), 64'd0);
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    chk("drop_valid", 64'(bus.if_valid_o), 64'd0);
    chk("drop_req", 64'(bus.imem_req_o), 64'd1);
    chk("drop_addr", bus.imem_addr_o, 64'h8000_0100);

    // Redirect in FULL beats a same-cycle accept
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; held = 32'h0050_0113; bus.imem_rdata_i = held;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    chk("full_valid", 64'(bus.if_valid_o), 64'd1);
    chk("full_pc", bus.if_pc_o, 64'h8000_0100);
    redir = 1'b1; rpc = 64'h8000_0200; bus.if_ready_i = 1'b1;
    @(negedge clk);
    redir = 1'b0; bus.if_ready_i = 1'b0;
    chk("rf_valid", 64'(bus.if_valid_o), 64'd0);
    chk("rf_req", 64'(bus.imem_req_o), 64'd1);
    chk("rf_addr", bus.imem_addr_o, 64'h8000_0200);

`ifdef IFU_FAULT_CHECK_EN
    redir = 1'b1; rpc = 64'h8000_0102;
    @(negedge clk);
    redir = 1'b0;
    chk("mis_req", 64'(bus.imem_req_o), 64'd0);
    chk("mis_valid", 64'(bus.if_valid_o), 64'd1);
    chk("mis_fault", 64'(bus.if_fault_o), 64'd1);
    chk("mis_pc", bus.if_pc_o, 64'h8000_0102);
    chk("mis_instr", 64'(bus.if_instr_o), 64'(NOP));
    bus.if_ready_i = 1'b1;
    @(negedge clk);
    bus.if_ready_i = 1'b0;
    chk("mis_resume", bus.imem_addr_o, 64'h8000_0106);
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_err_i = 1'b1;
    bus.imem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0; bus.imem_err_i = 1'b0;
    chk("err_fault", 64'(bus.if_fault_o), 64'd1);
    chk("err_instr", 64'(bus.if_instr_o), 64'h1234_5678);
    chk("err_pc", bus.if_pc_o, 64'h8000_0106);
`else
    redir = 1'b1; rpc = 64'h8000_0102;
    @(negedge clk);
    redir = 1'b0;
    chk("pass_req", 64'(bus.imem_req_o), 64'd1);
    chk("pass_addr", bus.imem_addr_o, 64'h8000_0102);
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_err_i = 1'b1;
    bus.imem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0; bus.imem_err_i = 1'b0;
    chk("noerr_valid", 64'(bus.if_valid_o), 64'd1);
    chk("noerr_fault", 64'(bus.if_fault_o), 64'd0);
    chk("noerr_pc", bus.if_pc_o, 64'h8000_0102);
`endif
    bus.if_ready_i = 1'b1;
    @(negedge clk);
    bus.if_ready_i = 1'b0;

    // Async reset in WAIT
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.if_valid_o), 64'd0);
    chk("ar_pc", bus.if_pc_o, 64'd0);
    chk("ar_instr", 64'(bus.if_instr_o), 64'(NOP));
    chk("ar_fault", 64'(bus.if_fault_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("ar_req", 64'(bus.imem_req_o), 64'd1);
    chk("ar_addr", bus.imem_addr_o, RESET_PC);

    // Randomized traffic; memory answers each grant after 1..3 cycles
    busy = 1'b0; lat = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = bus.imem_req_o;
      g  = r && !busy && ($urandom_range(0, 1) == 1);
      rv = busy && (lat == 0);
      bus.imem_gnt_i    = g;
      bus.imem_rvalid_i = rv;
      bus.imem_rdata_i  = $urandom;
      bus.imem_err_i    = ($urandom_range(0, 3) == 0);
      bus.if_ready_i    = ($urandom_range(0, 2) != 0);
      redir             = ($urandom_range(0, 7) == 0);
      rpc               = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      @(negedge clk);
      if (g) begin busy = 1'b1; lat = $urandom_range(0, 2); end
      else if (rv) busy = 1'b0;
      else if (busy && lat != 0) lat--;
    end

    clr_in();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
